// File: rtl/uart_cmd_ctrl.sv
// UART command controller: parses R/W packets (CMD, ADDR_H, ADDR_L, LEN) and bridges them
// to an 8755-style byte memory with ACK/NAK responses and an inter-byte timeout.
module uart_cmd_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 500000,
    parameter logic [7:0]  ACK_BYTE       = 8'h06,
    parameter logic [7:0]  NAK_BYTE       = 8'h15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_data,
    input  logic        new_rx_data,
    output logic [7:0]  tx_data,
    output logic        new_tx_data,
    input  logic        tx_busy,
    output logic [10:0] mem_addr,
    output logic [7:0]  mem_wdata,
    output logic        mem_rd,
    output logic        mem_wr,
    input  logic [7:0]  mem_rdata,
    input  logic        mem_ack,
    output logic        busy,
    output logic        err
);

    localparam logic [7:0] CmdRead  = 8'h52;
    localparam logic [7:0] CmdWrite = 8'h57;

    // The counter never needs to hold TIMEOUT_CYCLES itself, only up to TIMEOUT_CYCLES-1.
    localparam int unsigned TmoW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TmoW-1:0] TmoLast = TmoW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [3:0] {
        StIdle,
        StGetAh,
        StGetAl,
        StGetLen,
        StGetData,
        StMemWr,
        StMemRd,
        StSend,
        StSendWait
    } state_e;

    state_e          state_q;
    logic            is_rd_q;
    logic [10:0]     addr_q;
    logic [7:0]      wdata_q;
    logic [7:0]      len_q;
    logic [TmoW-1:0] tmo_q;
    logic [7:0]      tx_data_q;
    logic            new_tx_q;
    logic            mem_rd_q;
    logic            mem_wr_q;
    logic            err_q;
    logic            sw_first_q;

    logic in_get;
    logic tmo_hit;

    assign in_get  = (state_q == StGetAh) || (state_q == StGetAl) ||
                     (state_q == StGetLen) || (state_q == StGetData);
    assign tmo_hit = in_get && !new_rx_data && (tmo_q == TmoLast);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= StIdle;
            is_rd_q    <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            len_q      <= '0;
            tmo_q      <= '0;
            tx_data_q  <= '0;
            new_tx_q   <= 1'b0;
            mem_rd_q   <= 1'b0;
            mem_wr_q   <= 1'b0;
            err_q      <= 1'b0;
            sw_first_q <= 1'b0;
        end else begin
            new_tx_q <= 1'b0;
            err_q    <= 1'b0;

            if (new_rx_data || !in_get || tmo_hit) begin
                tmo_q <= '0;
            end else begin
                tmo_q <= tmo_q + TmoW'(1);
            end

            if (tmo_hit) begin
                // Incomplete packet: discard silently apart from the err pulse.
                state_q <= StIdle;
                err_q   <= 1'b1;
            end else begin
                case (state_q)
                    StIdle: begin
                        if (new_rx_data) begin
                            if (rx_data == CmdRead || rx_data == CmdWrite) begin
                                is_rd_q <= (rx_data == CmdRead);
                                state_q <= StGetAh;
                            end else begin
                                tx_data_q <= NAK_BYTE;
                                len_q     <= '0;
                                err_q     <= 1'b1;
                                state_q   <= StSend;
                            end
                        end
                    end
                    StGetAh: begin
                        if (new_rx_data) begin
                            addr_q[10:8] <= rx_data[2:0];
                            state_q      <= StGetAl;
                        end
                    end
                    StGetAl: begin
                        if (new_rx_data) begin
                            addr_q[7:0] <= rx_data;
                            state_q     <= StGetLen;
                        end
                    end
                    StGetLen: begin
                        if (new_rx_data) begin
                            if (rx_data == 8'h00) begin
                                tx_data_q <= NAK_BYTE;
                                len_q     <= '0;
                                err_q     <= 1'b1;
                                state_q   <= StSend;
                            end else begin
                                len_q <= rx_data;
                                if (is_rd_q) begin
                                    mem_rd_q <= 1'b1;
                                    state_q  <= StMemRd;
                                end else begin
                                    state_q <= StGetData;
                                end
                            end
                        end
                    end
                    StGetData: begin
                        if (new_rx_data) begin
                            wdata_q  <= rx_data;
                            mem_wr_q <= 1'b1;
                            state_q  <= StMemWr;
                        end
                    end
                    StMemWr: begin
                        if (mem_ack) begin
                            mem_wr_q <= 1'b0;
                            addr_q   <= addr_q + 11'd1;
                            len_q    <= len_q - 8'd1;
                            if (len_q == 8'd1) begin
                                tx_data_q <= ACK_BYTE;
                                state_q   <= StSend;
                            end else begin
                                state_q <= StGetData;
                            end
                        end
                    end
                    StMemRd: begin
                        if (mem_ack) begin
                            mem_rd_q  <= 1'b0;
                            tx_data_q <= mem_rdata;
                            addr_q    <= addr_q + 11'd1;
                            len_q     <= len_q - 8'd1;
                            state_q   <= StSend;
                        end
                    end
                    StSend: begin
                        if (!tx_busy) begin
                            new_tx_q   <= 1'b1;
                            sw_first_q <= 1'b1;
                            state_q    <= StSendWait;
                        end
                    end
                    StSendWait: begin
                        // The transmitter may not raise tx_busy until a cycle after the strobe.
                        if (sw_first_q) begin
                            sw_first_q <= 1'b0;
                        end else if (!tx_busy) begin
                            if (is_rd_q && len_q != 8'd0) begin
                                mem_rd_q <= 1'b1;
                                state_q  <= StMemRd;
                            end else begin
                                state_q <= StIdle;
                            end
                        end
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

    assign tx_data     = tx_data_q;
    assign new_tx_data = new_tx_q;
    assign mem_addr    = addr_q;
    assign mem_wdata   = wdata_q;
    assign mem_rd      = mem_rd_q;
    assign mem_wr      = mem_wr_q;
    assign err         = err_q;
    assign busy        = (state_q != StIdle);

    a_rd_wr_excl: assert property (@(posedge clk) disable iff (!rst) !(mem_rd && mem_wr));
    a_tx_one_cycle: assert property (@(posedge clk) disable iff (!rst)
                                     new_tx_data |=> !new_tx_data);

endmodule

// File: doc/uart_cmd_ctrl.md
UART_CMD_CTRL -- requirements
Module: uart_cmd_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 500000, meaning idle cycles between received bytes before an incomplete packet is discarded.
REQ-002 SHALL have parameter ACK_BYTE, default 8'h06, meaning the byte sent after a successful write.
REQ-003 SHALL have parameter NAK_BYTE, default 8'h15, meaning the byte sent for an invalid command or a zero length.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, asynchronous and active-low.
REQ-006 SHALL have port rx_data, input, 8 bits: received byte from the UART.
REQ-007 SHALL have port new_rx_data, input, 1 bit: one-cycle strobe marking rx_data valid.
REQ-008 SHALL have port tx_data, output, 8 bits: byte to transmit.
REQ-009 SHALL have port new_tx_data, output, 1 bit: one-cycle transmit strobe.
REQ-010 SHALL have port tx_busy, input, 1 bit: the transmitter is busy.
REQ-011 SHALL have port mem_addr, output, 11 bits: 8755 byte address.
REQ-012 SHALL have port mem_wdata, output, 8 bits: write data.
REQ-013 SHALL have ports mem_rd and mem_wr, outputs, 1 bit each: level request signals.
REQ-014 SHALL have port mem_rdata, input, 8 bits: read data, valid when mem_ack is high.
REQ-015 SHALL have port mem_ack, input, 1 bit: one-cycle request completion.
REQ-016 SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.
REQ-017 SHALL have port err, output, 1 bit: one-cycle pulse on a NAK or a timeout.

Function
REQ-018 SHALL accept the packet CMD, ADDR_H, ADDR_L, LEN; CMD 8'h52 ('R') is a read and CMD 8'h57 ('W') is a write.
REQ-019 SHALL form the address as {ADDR_H[2:0], ADDR_L}; ADDR_H[7:3] is ignored.
REQ-020 SHALL use states IDLE, GET_AH, GET_AL, GET_LEN, GET_DATA, MEM_WR, MEM_RD, SEND, SEND_WAIT.
REQ-021 SHALL, in IDLE on a new_rx_data strobe: go to GET_AH for 'R' or 'W'; otherwise queue NAK_BYTE, pulse err and go to SEND.
REQ-022 SHALL treat LEN=0 as an error: queue NAK_BYTE, pulse err, perform no memory access.
REQ-023 SHALL, for a write, accept LEN data bytes; each byte goes GET_DATA -> MEM_WR; after the last write, queue ACK_BYTE.
REQ-024 SHALL, for a read, perform LEN iterations of MEM_RD -> SEND; no ACK is sent after a read.
REQ-025 SHALL hold mem_rd/mem_wr high from state entry until the cycle mem_ack is sampled high, and drop them on the next cycle.
REQ-026 SHALL never assert mem_rd and mem_wr together; at most one request is outstanding.
REQ-027 SHALL keep mem_addr and mem_wdata stable while a request is high.
REQ-028 SHALL latch mem_rdata into tx_data on mem_ack.
REQ-029 SHALL increment the address after each ack; 11'h7FF wraps to 11'h000.
REQ-030 SHALL, in SEND, pulse new_tx_data for exactly one cycle when tx_busy=0, then go to SEND_WAIT.
REQ-031 SHALL, in SEND_WAIT, ignore tx_busy for one cycle, then wait for tx_busy=0 before continuing (next read, or IDLE).
REQ-032 SHALL keep tx_data stable from the strobe until leaving SEND_WAIT.
REQ-033 SHALL clear the timeout counter on every new_rx_data strobe and count only in GET_AH, GET_AL, GET_LEN and GET_DATA.
REQ-034 SHALL, on reaching TIMEOUT_CYCLES, go to IDLE, pulse err and send no response.
REQ-035 SHALL drop bytes that arrive in MEM_WR, MEM_RD, SEND or SEND_WAIT, with no state change.
REQ-036 SHALL hold the remaining-byte count in 8 bits and finish the packet when it decrements to 0.

Reset
REQ-037 SHALL, while rst=0 (asynchronous), force: state IDLE; mem_rd, mem_wr, new_tx_data, busy and err 0; tx_data, mem_addr, mem_wdata and the counters 0.
REQ-038 SHALL abandon any transaction in progress on reset, including deasserting a pending memory request immediately.

Verification
REQ-039 Write: 57 00 10 02 AA BB -> mem_wr at 0x010=AA, then 0x011=BB; then tx 06.
REQ-040 Read with wrap: 52 07 FF 02, memory returns 11 then 22 -> reads at 0x7FF then 0x000; tx 11, 22; no ACK.
REQ-041 Errors: CMD 41 -> tx 15 and err pulse; 57 00 00 00 -> tx 15 and no mem_wr.
REQ-042 Timeout: 57 01, then silence for TIMEOUT_CYCLES -> err pulse, IDLE, no tx; a following valid packet completes normally.
REQ-043 Backpressure: hold tx_busy=1 for 100 cycles during a read -> new_tx_data held off; exactly one strobe per byte.
REQ-044 Reset: rst=0 while mem_wr is pending -> mem_wr drops asynchronously; busy=0; a subsequent write packet succeeds.
